// File: rtl/maze_mem_arbiter_if.sv
// Bundle of the two agent request ports and the single maze memory port.
// The arbiter takes the slave side and the agents/memory take the master side.
interface maze_mem_arbiter_if;
    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic [5:0] row0;
    logic [5:0] col0;
    logic [5:0] row1;
    logic [5:0] col1;
    logic       ack0;
    logic       ack1;
    logic       rdata;
    logic       busy;
    logic       owner;
    logic [5:0] row;
    logic [5:0] col;
    logic       maze_oe;
    logic       maze_we;
    logic       maze_in;

    modport slave (
        input  req0, req1, we0, we1, row0, col0, row1, col1, maze_in,
        output ack0, ack1, rdata, busy, owner, row, col, maze_oe, maze_we
    );

    modport master (
        output req0, req1, we0, we1, row0, col0, row1, col1, maze_in,
        input  ack0, ack1, rdata, busy, owner, row, col, maze_oe, maze_we
    );
endinterface

// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter letting two maze-solver agents share one maze memory port.
// Every output is a flop; the next-state logic below computes their next values.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no access; arbitrate req0/req1 and latch the winner's cell
//   S_ISSUE | one-cycle maze_oe (read) or maze_we (write) pulse
//   S_WAIT  | counting down read latency; capture maze_in at count 0
//   S_ACK   | one-cycle ack to the owner
module maze_mem_arbiter #(
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    maze_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    localparam logic [1:0] WAIT_LOAD = 2'(READ_LAT - 1);

    state_t     state, state_n;
    logic       owner_q, owner_n;
    logic       last_q, last_n;
    logic       we_q, we_n;
    logic       rdata_q, rdata_n;
    logic       ack0_q, ack0_n;
    logic       ack1_q, ack1_n;
    logic       oe_q, oe_n;
    logic       mwe_q, mwe_n;
    logic       busy_q, busy_n;
    logic [5:0] row_q, row_n;
    logic [5:0] col_q, col_n;
    logic [1:0] cnt_q, cnt_n;
    logic       grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            rdata_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            oe_q    <= 1'b0;
            mwe_q   <= 1'b0;
            busy_q  <= 1'b0;
            row_q   <= 6'd0;
            col_q   <= 6'd0;
            cnt_q   <= 2'd0;
        end else begin
            state   <= state_n;
            owner_q <= owner_n;
            last_q  <= last_n;
            we_q    <= we_n;
            rdata_q <= rdata_n;
            ack0_q  <= ack0_n;
            ack1_q  <= ack1_n;
            oe_q    <= oe_n;
            mwe_q   <= mwe_n;
            busy_q  <= busy_n;
            row_q   <= row_n;
            col_q   <= col_n;
            cnt_q   <= cnt_n;
        end
    end

    // On a tie the agent that was not served last wins.
    always_comb begin
        grant = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    end

    always_comb begin
        state_n = state;
        owner_n = owner_q;
        last_n  = last_q;
        we_n    = we_q;
        rdata_n = rdata_q;
        row_n   = row_q;
        col_n   = col_q;
        cnt_n   = cnt_q;
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        oe_n    = 1'b0;
        mwe_n   = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_n = S_ISSUE;
                    owner_n = grant;
                    last_n  = grant;
                    we_n    = grant ? bus.we1  : bus.we0;
                    row_n   = grant ? bus.row1 : bus.row0;
                    col_n   = grant ? bus.col1 : bus.col0;
                    oe_n    = ~we_n;
                    mwe_n   = we_n;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_n = S_ACK;
                    ack0_n  = ~owner_q;
                    ack1_n  = owner_q;
                end else begin
                    state_n = S_WAIT;
                    cnt_n   = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_n = S_ACK;
                    rdata_n = bus.maze_in;
                    ack0_n  = ~owner_q;
                    ack1_n  = owner_q;
                end else begin
                    cnt_n = cnt_q - 2'd1;
                end
            end
            S_ACK: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = busy_q;
    assign bus.owner   = owner_q;
    assign bus.row     = row_q;
    assign bus.col     = col_q;
    assign bus.maze_oe = oe_q;
    assign bus.maze_we = mwe_q;
endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Bench for maze_mem_arbiter: two instances (READ_LAT 1 and 3) over a behavioural
// maze memory where cells with (row+col)%7==0 are walls and marker writes set a cell to 1.
module tb_maze_mem_arbiter;
    typedef struct {
        bit agent;
        bit is_read;
        bit data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    bit   marks[64][64];
    bit   exp_marks[64][64];
    logic p1 = 1'b0;
    logic [2:0] p3 = 3'b000;

    always #5 clk = ~clk;

    maze_mem_arbiter_if m1();
    maze_mem_arbiter_if m3();

    maze_mem_arbiter #(.READ_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(m1));
    maze_mem_arbiter #(.READ_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(m3));

    function automatic bit wall(input int r, input int c);
        return ((r + c) % 7) == 0;
    endfunction

    function automatic bit mem_cell(input logic [5:0] r, input logic [5:0] c);
        return marks[r][c] | wall(int'(r), int'(c));
    endfunction

    function automatic bit exp_cell(input int r, input int c);
        return exp_marks[r][c] | wall(r, c);
    endfunction

    // Memory: data appears READ_LAT cycles after the maze_oe cycle; toggles otherwise.
    always @(posedge clk) begin
        if (m1.maze_we) marks[m1.row][m1.col] <= 1'b1;
        p1 <= m1.maze_oe ? mem_cell(m1.row, m1.col) : ~p1;
        p3 <= {p3[1:0], (m3.maze_oe ? mem_cell(m3.row, m3.col) : ~p3[0])};
    end
    assign m1.maze_in = p1;
    assign m3.maze_in = p3[2];

    task automatic test_reset();
        m1.req0 = 0; m1.req1 = 0; m1.we0 = 0; m1.we1 = 0;
        m1.row0 = 0; m1.col0 = 0; m1.row1 = 0; m1.col1 = 0;
        m3.req0 = 0; m3.req1 = 0; m3.we0 = 0; m3.we1 = 0;
        m3.row0 = 0; m3.col0 = 0; m3.row1 = 0; m3.col1 = 0;
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if ({m1.ack0, m1.ack1, m1.rdata, m1.busy, m1.owner, m1.maze_oe, m1.maze_we} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {m1.ack0, m1.ack1, m1.rdata, m1.busy, m1.owner, m1.maze_oe, m1.maze_we});
        end
        n_checks++;
        if ({m1.row, m1.col} !== 12'd0) begin
            n_fail++; $display("FAIL reset_addr got row=%0d col=%0d want 0,0", m1.row, m1.col);
        end
        n_checks++;
        if ({m3.busy, m3.maze_oe, m3.rdata} !== 3'b0) begin
            n_fail++; $display("FAIL reset_lat3 got %b want 000", {m3.busy, m3.maze_oe, m3.rdata});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        int oe_cnt = 0;
        m1.req0 = 1; m1.we0 = 1; m1.row0 = 5; m1.col0 = 7;
        exp_q.push_back('{agent: 1'b0, is_read: 1'b0, data: 1'b0});
        exp_marks[5][7] = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            if (m1.maze_oe) oe_cnt++;
            if (cyc == 1) begin
                n_checks++;
                if ({m1.maze_we, m1.busy, m1.owner, m1.row, m1.col} !== {1'b1, 1'b1, 1'b0, 6'd5, 6'd7}) begin
                    n_fail++;
                    $display("FAIL wr_issue got we=%b busy=%b owner=%b row=%0d col=%0d want 1 1 0 5 7",
                             m1.maze_we, m1.busy, m1.owner, m1.row, m1.col);
                end
            end
            if (cyc == 2) begin
                n_checks++;
                if (m1.ack0 !== 1'b1 || exp_q.size() == 0) begin
                    n_fail++; $display("FAIL wr_ack got ack0=%b want 1", m1.ack0);
                end else begin
                    exp_t e = exp_q.pop_front();
                    if (e.agent !== 1'b0) begin
                        n_fail++; $display("FAIL wr_ack_agent got 0 want %b", e.agent);
                    end
                end
            end
            if (cyc == 3) begin
                n_checks++;
                if (m1.busy !== 1'b0) begin
                    n_fail++; $display("FAIL wr_idle got busy=%b want 0", m1.busy);
                end
            end
            @(posedge clk); #1;
            if (cyc == 2) m1.req0 = 0;
        end
        n_checks++;
        if (oe_cnt != 0) begin
            n_fail++; $display("FAIL wr_no_oe got %0d oe cycles want 0", oe_cnt);
        end
    endtask

    task automatic test_single_read();
        m1.req1 = 1; m1.we1 = 0; m1.row1 = 3; m1.col1 = 4;
        m3.req1 = 1; m3.we1 = 0; m3.row1 = 3; m3.col1 = 4;
        exp_q.push_back('{agent: 1'b1, is_read: 1'b1, data: exp_cell(3, 4)});
        @(posedge clk);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                n_checks++;
                if ({m1.maze_oe, m1.owner, m3.maze_oe, m1.maze_we} !== 4'b1110) begin
                    n_fail++;
                    $display("FAIL rd_issue got oe=%b owner=%b oe3=%b we=%b want 1 1 1 0",
                             m1.maze_oe, m1.owner, m3.maze_oe, m1.maze_we);
                end
            end
            n_checks++;
            if (m1.ack1 !== (cyc == 3) || m3.ack1 !== (cyc == 5)) begin
                n_fail++;
                $display("FAIL rd_ack_timing cycle %0d got ack1=%b ack1_lat3=%b want %b %b",
                         cyc, m1.ack1, m3.ack1, (cyc == 3), (cyc == 5));
            end
            if (cyc == 3 && exp_q.size() != 0) begin
                exp_t e = exp_q.pop_front();
                n_checks++;
                if (m1.ack1 !== e.agent || m1.rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL rd_lat1_data got ack1=%b rdata=%b want %b %b", m1.ack1, m1.rdata, e.agent, e.data);
                end
            end
            if (cyc == 5) begin
                n_checks++;
                if (m3.rdata !== 1'b1) begin
                    n_fail++; $display("FAIL rd_lat3_data got rdata=%b want 1", m3.rdata);
                end
            end
            @(posedge clk); #1;
            if (cyc == 3) m1.req1 = 0;
            if (cyc == 5) m3.req1 = 0;
        end
    endtask

    task automatic test_tie_alternate();
        int acks = 0;
        m1.req0 = 1; m1.we0 = 0; m1.row0 = 1; m1.col0 = 6;
        m1.req1 = 1; m1.we1 = 0; m1.row1 = 2; m1.col1 = 2;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{agent: 1'b0, is_read: 1'b1, data: exp_cell(1, 6)});
            exp_q.push_back('{agent: 1'b1, is_read: 1'b1, data: exp_cell(2, 2)});
        end
        for (int cyc = 0; cyc < 40 && acks < 4; cyc++) begin
            @(negedge clk);
            if (m1.ack0 || m1.ack1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL tie_unexpected_ack got ack0=%b ack1=%b", m1.ack0, m1.ack1);
                end else begin
                    exp_t e = exp_q.pop_front();
                    if (m1.ack1 !== e.agent || m1.ack0 !== ~e.agent || m1.rdata !== e.data) begin
                        n_fail++;
                        $display("FAIL tie_order access %0d got ack0=%b ack1=%b rdata=%b want agent %b rdata %b",
                                 acks, m1.ack0, m1.ack1, m1.rdata, e.agent, e.data);
                    end
                end
                acks++;
            end
            @(posedge clk); #1;
        end
        m1.req0 = 0; m1.req1 = 0;
        n_checks++;
        if (acks != 4) begin
            n_fail++; $display("FAIL tie_timeout got %0d acks want 4", acks);
        end
    endtask

    task automatic test_dropped_req();
        int oe_cnt = 0;
        m1.req1 = 1; m1.we1 = 0; m1.row1 = 63; m1.col1 = 0;
        exp_q.push_back('{agent: 1'b1, is_read: 1'b1, data: exp_cell(63, 0)});
        @(posedge clk);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (m1.maze_oe) oe_cnt++;
            if (cyc == 1) begin
                n_checks++;
                if ({m1.row, m1.col} !== {6'd63, 6'd0}) begin
                    n_fail++; $display("FAIL drop_addr got row=%0d col=%0d want 63 0", m1.row, m1.col);
                end
            end
            if (cyc == 3) begin
                n_checks++;
                if (m1.ack1 !== 1'b1 || exp_q.size() == 0) begin
                    n_fail++; $display("FAIL drop_ack got ack1=%b want 1", m1.ack1);
                end else begin
                    exp_t e = exp_q.pop_front();
                    if (m1.rdata !== e.data) begin
                        n_fail++; $display("FAIL drop_rdata got %b want %b", m1.rdata, e.data);
                    end
                end
            end
            @(posedge clk); #1;
            if (cyc == 1) m1.req1 = 0;
        end
        n_checks++;
        if (oe_cnt != 1) begin
            n_fail++; $display("FAIL drop_single_access got %0d oe cycles want 1", oe_cnt);
        end
    endtask

    task automatic test_addr_bounds();
        m1.req0 = 1; m1.we0 = 1; m1.row0 = 0; m1.col0 = 63;
        exp_q.push_back('{agent: 1'b0, is_read: 1'b0, data: 1'b0});
        exp_marks[0][63] = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 2; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                n_checks++;
                if ({m1.maze_we, m1.row, m1.col} !== {1'b1, 6'd0, 6'd63}) begin
                    n_fail++;
                    $display("FAIL bound_addr got we=%b row=%0d col=%0d want 1 0 63", m1.maze_we, m1.row, m1.col);
                end
            end
            if (cyc == 2) begin
                n_checks++;
                if (m1.ack0 !== 1'b1 || m1.rdata !== 1'b1 || exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bound_ack got ack0=%b rdata=%b want 1 1 (rdata held)", m1.ack0, m1.rdata);
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            @(posedge clk); #1;
            if (cyc == 2) m1.req0 = 0;
        end
    endtask

    task automatic test_write_then_read();
        bit done0 = 0;
        bit done1 = 0;
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        m1.req0 = 1; m1.we0 = 1; m1.row0 = 10; m1.col0 = 10;
        m1.req1 = 1; m1.we1 = 0; m1.row1 = 10; m1.col1 = 10;
        exp_q.push_back('{agent: 1'b0, is_read: 1'b0, data: 1'b0});
        exp_marks[10][10] = 1'b1;
        exp_q.push_back('{agent: 1'b1, is_read: 1'b1, data: exp_cell(10, 10)});
        for (int cyc = 0; cyc < 30 && !(done0 && done1); cyc++) begin
            @(negedge clk);
            if (m1.ack0 || m1.ack1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL wr_rd_unexpected_ack got ack0=%b ack1=%b", m1.ack0, m1.ack1);
                end else begin
                    exp_t e = exp_q.pop_front();
                    if (m1.ack1 !== e.agent || (e.is_read && m1.rdata !== e.data)) begin
                        n_fail++;
                        $display("FAIL wr_rd_order got ack1=%b rdata=%b want agent %b rdata %b",
                                 m1.ack1, m1.rdata, e.agent, e.data);
                    end
                end
                if (m1.ack0) done0 = 1;
                if (m1.ack1) done1 = 1;
            end
            @(posedge clk); #1;
            if (done0) m1.req0 = 0;
            if (done1) m1.req1 = 0;
        end
        m1.req0 = 0; m1.req1 = 0;
        n_checks++;
        if (!(done0 && done1)) begin
            n_fail++; $display("FAIL wr_rd_timeout got done=%b%b want 11", done0, done1);
        end
    endtask

    task automatic test_reset_mid_read();
        bit done0 = 0;
        bit done1 = 0;
        m1.req0 = 1; m1.we0 = 0; m1.row0 = 20; m1.col0 = 20;
        m3.req0 = 1; m3.we0 = 0; m3.row0 = 20; m3.col0 = 20;
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        m1.req0 = 0; m3.req0 = 0;
        n_checks++;
        if ({m1.maze_oe, m1.busy, m1.ack0, m1.ack1, m1.rdata, m3.busy, m3.ack0} !== 7'b0) begin
            n_fail++;
            $display("FAIL midrst_abort got oe=%b busy=%b ack=%b%b rdata=%b busy3=%b ack3=%b want all 0",
                     m1.maze_oe, m1.busy, m1.ack0, m1.ack1, m1.rdata, m3.busy, m3.ack0);
        end
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        m1.req0 = 1; m1.we0 = 1; m1.row0 = 30; m1.col0 = 1;
        m1.req1 = 1; m1.we1 = 1; m1.row1 = 30; m1.col1 = 2;
        exp_q.push_back('{agent: 1'b0, is_read: 1'b0, data: 1'b0});
        exp_q.push_back('{agent: 1'b1, is_read: 1'b0, data: 1'b0});
        exp_marks[30][1] = 1'b1;
        exp_marks[30][2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({m1.busy, m1.owner, m1.maze_we} !== 3'b101) begin
            n_fail++;
            $display("FAIL midrst_tie got busy=%b owner=%b we=%b want 1 0 1", m1.busy, m1.owner, m1.maze_we);
        end
        for (int cyc = 0; cyc < 30 && !(done0 && done1); cyc++) begin
            if (m1.ack0 || m1.ack1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL midrst_unexpected_ack got ack0=%b ack1=%b", m1.ack0, m1.ack1);
                end else begin
                    exp_t e = exp_q.pop_front();
                    if (m1.ack1 !== e.agent) begin
                        n_fail++; $display("FAIL midrst_order got ack1=%b want %b", m1.ack1, e.agent);
                    end
                end
                if (m1.ack0) done0 = 1;
                if (m1.ack1) done1 = 1;
            end
            @(posedge clk); #1;
            if (done0) m1.req0 = 0;
            if (done1) m1.req1 = 0;
            @(negedge clk);
        end
        m1.req0 = 0; m1.req1 = 0;
        n_checks++;
        if (!(done0 && done1)) begin
            n_fail++; $display("FAIL midrst_timeout got done=%b%b want 11", done0, done1);
        end
        n_checks++;
        if (marks[30][1] !== exp_marks[30][1] || marks[30][2] !== exp_marks[30][2]) begin
            n_fail++; $display("FAIL midrst_mem got %b%b want 11", marks[30][1], marks[30][2]);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_tie_alternate();
        test_dropped_req();
        test_addr_bounds();
        test_write_then_read();
        test_reset_mid_read();
        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
